// File: rtl/ahb_bus_matrix_pkg.sv
// Shared types for the AHB bus-matrix output-port arbiter slice:
// HTRANS encodings, port count, port index type and the pick helper.
`timescale 1ns/1ps
package ahb_bus_matrix_pkg;

  localparam int NPORTS = 3;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  // First requesting port found walking upward from start, wrapping.
  function automatic port_idx_t pick_port(
    input logic [NPORTS-1:0] req,
    input port_idx_t         start
  );
    port_idx_t p;
    logic      found;
    int        idx;
    p     = start;
    found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (int'(start) + k) % NPORTS;
      if (!found && req[idx]) begin
        p     = port_idx_t'(idx);
        found = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ahb_bus_matrix_arb3.sv
// Three-input grant selector for one bus-matrix output port.
// AHB_BUS_MATRIX_RR_ARB_EN selects round-robin, else fixed S0>S1>S2.
`timescale 1ns/1ps
module ahb_bus_matrix_arb3
  import ahb_bus_matrix_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ready,
  input  logic [NPORTS-1:0] i_req,
  input  logic [NPORTS-1:0] i_hold,
  output port_idx_t         o_port,
  output logic              o_no_port
);

  port_idx_t r_port;
  logic      r_no_port;
  port_idx_t w_start;
  logic      w_hold;

  // Only the port currently owning the address phase may hold it.
  assign w_hold = ~r_no_port & i_hold[r_port];

`ifdef AHB_BUS_MATRIX_RR_ARB_EN
  port_idx_t r_last;

  assign w_start = (r_last == port_idx_t'(NPORTS-1)) ?
                   '0 : r_last + 2'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_last <= port_idx_t'(NPORTS-1);
    else if (i_ready && !w_hold && (|i_req))
      r_last <= o_port;
  end
`else
  assign w_start = '0;
`endif

  always_comb begin
    o_port    = r_port;
    o_no_port = r_no_port;
    if (i_ready) begin
      if (w_hold) begin
        o_no_port = 1'b0;
      end else if (|i_req) begin
        o_port    = pick_port(i_req, w_start);
        o_no_port = 1'b0;
      end else begin
        o_no_port = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_port    <= '0;
      r_no_port <= 1'b1;
    end else begin
      r_port    <= o_port;
      r_no_port <= o_no_port;
    end
  end

endmodule

// File: rtl/ahb_bus_matrix_output_arb.sv
// AHB bus-matrix output stage: arbitrates S0..S2 onto one slave port.
// Build with AHB_BUS_MATRIX_RR_ARB_EN for round-robin arbitration.
`timescale 1ns/1ps
module ahb_bus_matrix_output_arb
  import ahb_bus_matrix_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  sel_op,
  input  logic [95:0] addr_op,
  input  logic [5:0]  trans_op,
  input  logic [2:0]  write_op,
  input  logic [8:0]  size_op,
  input  logic [8:0]  burst_op,
  input  logic [2:0]  mastlock_op,
  input  logic [95:0] wdata_op,
  input  logic        HREADYOUTM,
  output logic [2:0]  active_op,
  output logic        HSELM,
  output logic [31:0] HADDRM,
  output logic [1:0]  HTRANSM,
  output logic        HWRITEM,
  output logic [2:0]  HSIZEM,
  output logic [2:0]  HBURSTM,
  output logic        HMASTLOCKM,
  output logic [31:0] HWDATAM,
  output logic        HREADYMUXM
);

  logic [NPORTS-1:0] w_req;
  logic [NPORTS-1:0] w_hold;
  port_idx_t         w_port;
  logic              w_no_port;
  port_idx_t         r_data_port;
  logic              r_data_valid;

  // Bursts hold while still selected; a lock holds even across IDLE.
  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic [1:0] w_t;
    assign w_t       = trans_op[2*i +: 2];
    assign w_req[i]  = sel_op[i] & (w_t != TRANS_IDLE);
    assign w_hold[i] = mastlock_op[i] |
                       (sel_op[i] &
                        ((w_t == TRANS_SEQ) || (w_t == TRANS_BUSY)));
  end

  ahb_bus_matrix_arb3 u_arb (
    .i_clk     (HCLK),
    .i_rst_n   (HRESETn),
    .i_ready   (HREADYMUXM),
    .i_req     (w_req),
    .i_hold    (w_hold),
    .o_port    (w_port),
    .o_no_port (w_no_port)
  );

  assign active_op  = w_no_port ? 3'b000 : (3'b001 << w_port);
  assign HSELM      = sel_op[w_port] & ~w_no_port;
  assign HTRANSM    = w_no_port ? TRANS_IDLE : trans_op[2*w_port +: 2];
  assign HADDRM     = addr_op[32*w_port +: 32];
  assign HWRITEM    = write_op[w_port];
  assign HSIZEM     = size_op[3*w_port +: 3];
  assign HBURSTM    = burst_op[3*w_port +: 3];
  assign HMASTLOCKM = mastlock_op[w_port];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_data_port  <= '0;
      r_data_valid <= 1'b0;
    end else if (HREADYMUXM) begin
      r_data_port  <= w_port;
      r_data_valid <= HSELM & HTRANSM[1];
    end
  end

  assign HWDATAM    = wdata_op[32*r_data_port +: 32];
  assign HREADYMUXM = r_data_valid ? HREADYOUTM : 1'b1;

endmodule

// File: tb/tb_ahb_bus_matrix_output_arb.sv
// Self-checking bench for ahb_bus_matrix_output_arb (both arbiter builds).
`timescale 1ns/1ps
module tb_ahb_bus_matrix_output_arb;

`ifdef AHB_BUS_MATRIX_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  typedef struct packed {
    logic       rst;
    logic [2:0] sel;
    logic [5:0] tr;
    logic [2:0] lk;
    logic       hr;
    logic       esel;
    logic [1:0] etr;
    logic [1:0] eap;
    logic [2:0] eact;
    logic       erdy;
    logic [1:0] edp;
  } row_t;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  sel_op;
  logic [95:0] addr_op;
  logic [5:0]  trans_op;
  logic [2:0]  write_op;
  logic [8:0]  size_op;
  logic [8:0]  burst_op;
  logic [2:0]  mastlock_op;
  logic [95:0] wdata_op;
  logic        HREADYOUTM;
  logic [2:0]  active_op;
  logic        HSELM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM;
  logic [2:0]  HBURSTM;
  logic        HMASTLOCKM;
  logic [31:0] HWDATAM;
  logic        HREADYMUXM;

  logic [31:0] a_addr  [3] = '{32'h0000_1000, 32'h0000_0100, 32'h0000_2000};
  logic        a_wr    [3] = '{1'b0, 1'b1, 1'b1};
  logic [2:0]  a_size  [3] = '{3'd0, 3'd1, 3'd2};
  logic [2:0]  a_burst [3] = '{3'b001, 3'b000, 3'b011};

  logic [78:0] sb[$];
  int checks = 0;
  int errors = 0;

  ahb_bus_matrix_output_arb dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .sel_op      (sel_op),
    .addr_op     (addr_op),
    .trans_op    (trans_op),
    .write_op    (write_op),
    .size_op     (size_op),
    .burst_op    (burst_op),
    .mastlock_op (mastlock_op),
    .wdata_op    (wdata_op),
    .HREADYOUTM  (HREADYOUTM),
    .active_op   (active_op),
    .HSELM       (HSELM),
    .HADDRM      (HADDRM),
    .HTRANSM     (HTRANSM),
    .HWRITEM     (HWRITEM),
    .HSIZEM      (HSIZEM),
    .HBURSTM     (HBURSTM),
    .HMASTLOCKM  (HMASTLOCKM),
    .HWDATAM     (HWDATAM),
    .HREADYMUXM  (HREADYMUXM)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  function automatic logic [31:0] wd(input logic [1:0] p);
    return 32'hDDDD_0000 + {30'd0, p};
  endfunction

  function automatic row_t R(
    input logic       rst,
    input logic [2:0] sel,
    input logic [1:0] t2, input logic [1:0] t1, input logic [1:0] t0,
    input logic [2:0] lk,
    input logic       hr,
    input logic       esel,
    input logic [1:0] etr,
    input logic [1:0] eap,
    input logic [2:0] eact,
    input logic       erdy,
    input logic [1:0] edp
  );
    row_t r;
    r.rst  = rst;
    r.sel  = sel;
    r.tr   = {t2, t1, t0};
    r.lk   = lk;
    r.hr   = hr;
    r.esel = esel;
    r.etr  = etr;
    r.eap  = eap;
    r.eact = eact;
    r.erdy = erdy;
    r.edp  = edp;
    return r;
  endfunction

  function automatic logic [78:0] exp_of(input row_t r);
    return {r.esel, r.etr, a_addr[r.eap], a_wr[r.eap], a_size[r.eap],
            a_burst[r.eap], r.lk[r.eap], r.eact, r.erdy, wd(r.edp)};
  endfunction

  function automatic logic [78:0] obs();
    return {HSELM, HTRANSM, HADDRM, HWRITEM, HSIZEM, HBURSTM,
            HMASTLOCKM, active_op, HREADYMUXM, HWDATAM};
  endfunction

  task automatic apply_row(input row_t r);
    @(posedge HCLK);
    #1;
    HRESETn     = r.rst;
    sel_op      = r.sel;
    trans_op    = r.tr;
    mastlock_op = r.lk;
    HREADYOUTM  = r.hr;
    sb.push_back(exp_of(r));
  endtask

  task automatic do_reset();
    @(posedge HCLK);
    #1;
    HRESETn     = 1'b0;
    sel_op      = 3'b000;
    trans_op    = 6'd0;
    mastlock_op = 3'b000;
    HREADYOUTM  = 1'b1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [78:0] e;
    rows.push_back(R(1'b0, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd0, 3'b000, 1'b1, 2'd0));
    rows.push_back(R(1'b0, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd0, 3'b000, 1'b1, 2'd0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_single_write();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b010, TI, TN, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd1, 3'b010, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd1, 3'b000, 1'b1, 2'd1));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd1, 3'b000, 1'b1, 2'd1));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL single row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_contention();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b101, TN, TI, TN, 3'b000, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b101, TN, TI, TN, 3'b000, 1'b1,
                     1'b1, TN, RR ? 2'd2 : 2'd0,
                     RR ? 3'b100 : 3'b001, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, RR ? 2'd2 : 2'd0,
                     3'b000, 1'b1, RR ? 2'd2 : 2'd0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL contend row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_burst_hold();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b100, TN, TI, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd2, 3'b100, 1'b1, 2'd0));
    for (int b = 0; b < 3; b++)
      rows.push_back(R(1'b1, 3'b101, TS, TI, TN, 3'b000, 1'b1,
                       1'b1, TS, 2'd2, 3'b100, 1'b1, 2'd2));
    rows.push_back(R(1'b1, 3'b001, TI, TI, TN, 3'b000, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd2));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd0, 3'b000, 1'b1, 2'd0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL burst row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_sel_drop();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b100, TN, TI, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd2, 3'b100, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b001, TS, TI, TN, 3'b000, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd2));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL seldrop row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_wait_states();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b010, TI, TN, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd1, 3'b010, 1'b1, 2'd0));
    for (int w = 0; w < 3; w++)
      rows.push_back(R(1'b1, 3'b001, TI, TI, TN, 3'b000, 1'b0,
                       1'b0, TI, 2'd1, 3'b010, 1'b0, 2'd1));
    rows.push_back(R(1'b1, 3'b001, TI, TI, TN, 3'b000, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd1));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd0, 3'b000, 1'b1, 2'd0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL wait row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_locked();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b011, TI, TN, TN, 3'b001, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b011, TI, TN, TI, 3'b001, 1'b1,
                     1'b1, TI, 2'd0, 3'b001, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b011, TI, TN, TN, 3'b001, 1'b1,
                     1'b1, TN, 2'd0, 3'b001, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b010, TI, TN, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd1, 3'b010, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b1,
                     1'b0, TI, 2'd1, 3'b000, 1'b1, 2'd1));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL lock row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    row_t rows[$];
    logic [78:0] e;
    do_reset();
    rows.push_back(R(1'b1, 3'b010, TI, TN, TI, 3'b000, 1'b1,
                     1'b1, TN, 2'd1, 3'b010, 1'b1, 2'd0));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b0,
                     1'b0, TI, 2'd1, 3'b010, 1'b0, 2'd1));
    rows.push_back(R(1'b0, 3'b000, TI, TI, TI, 3'b000, 1'b0,
                     1'b0, TI, 2'd1, 3'b010, 1'b0, 2'd1));
    rows.push_back(R(1'b1, 3'b000, TI, TI, TI, 3'b000, 1'b0,
                     1'b0, TI, 2'd0, 3'b000, 1'b1, 2'd0));
    foreach (rows[k]) begin
      apply_row(rows[k]);
      @(negedge HCLK);
      e = sb.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rstmid row%0d got=%h exp=%h", k, obs(), e);
      end
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    sel_op      = 3'b000;
    trans_op    = 6'd0;
    mastlock_op = 3'b000;
    HREADYOUTM  = 1'b1;
    addr_op     = {a_addr[2], a_addr[1], a_addr[0]};
    write_op    = {a_wr[2], a_wr[1], a_wr[0]};
    size_op     = {a_size[2], a_size[1], a_size[0]};
    burst_op    = {a_burst[2], a_burst[1], a_burst[0]};
    wdata_op    = {wd(2'd2), wd(2'd1), wd(2'd0)};
    test_reset();
    test_single_write();
    test_contention();
    test_burst_hold();
    test_sel_drop();
    test_wait_states();
    test_locked();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
